// File: rtl/grid_io_column_cfg.sv
// IO column tile: NUM_IO bidirectional pads configured through a daisy-chained shift register,
// committed to a shadow register by a validated load. Optional feature macro: GRID_IO_PARITY_EN.
module grid_io_column_cfg #(
  parameter int NUM_IO   = 8,
  parameter int CFG_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              ccff_head,
  input  logic              ccff_en,
  input  logic              ccff_load,
  input  logic [NUM_IO-1:0] io_outpad,
  inout  wire  [NUM_IO-1:0] gfpga_pad_iopad_pad,
  output logic [NUM_IO-1:0] io_inpad,
  output logic              ccff_tail,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int CFG_W = NUM_IO * CFG_BITS;
`ifdef GRID_IO_PARITY_EN
  localparam int CHAIN_LEN = CFG_W + 1;
`else
  localparam int CHAIN_LEN = CFG_W;
`endif
  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  localparam logic [0:0] ST_UNCONF = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CFG_W-1:0]     shadow_q, shadow_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [0:0]           state_q, state_d;
  logic                 err_q, err_d;

  logic [CFG_W-1:0]     sr_cfg;
  logic                 chain_ok;
  logic                 load_ok;

  // With parity the last-shifted bit sits at sr[0]; config occupies the bits above it.
`ifdef GRID_IO_PARITY_EN
  assign sr_cfg   = sr_q[CHAIN_LEN-1:1];
  assign chain_ok = ~(^sr_q);
`else
  assign sr_cfg   = sr_q;
  assign chain_ok = 1'b1;
`endif

  assign load_ok = (cnt_q == CNT_W'(CHAIN_LEN)) && chain_ok;

  always_comb begin
    sr_d     = sr_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    err_d    = err_q;

    if (ccff_load) begin
      if (load_ok) begin
        shadow_d = sr_cfg;
        state_d  = ST_ACTIVE;
        err_d    = 1'b0;
        cnt_d    = '0;
      end else begin
        shadow_d = '0;
        state_d  = ST_UNCONF;
        err_d    = 1'b1;
      end
    end

    // Load sees pre-shift values; the shift in the same cycle still counts toward the next load.
    if (ccff_en) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
      if (cnt_d != CNT_W'(CHAIN_LEN)) begin
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      sr_q     <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
      state_q  <= ST_UNCONF;
      err_q    <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail = sr_q[CHAIN_LEN-1];
  assign cfg_done  = (state_q == ST_ACTIVE);
  assign cfg_err   = err_q;

  // Pads release combinationally while reset is asserted, ahead of the state clearing.
  logic pad_active;
  assign pad_active = cfg_done & ~pReset;

  for (genvar i = 0; i < NUM_IO; i++) begin : g_pad
    logic dir;
    logic inv;
    assign dir = shadow_q[CFG_BITS*i];
    assign inv = shadow_q[CFG_BITS*i+1];
    assign gfpga_pad_iopad_pad[i] = (pad_active && dir) ? (io_outpad[i] ^ inv) : 1'bz;
    assign io_inpad[i] = (pad_active && !dir) ? (gfpga_pad_iopad_pad[i] ^ inv) : 1'b0;
  end

endmodule
